// File: rtl/sdf_ntt_ctrl_if.sv
// rtl/sdf_ntt_ctrl_if.sv - handshake and sequencing bus of the SDF NTT controller
interface sdf_ntt_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic                     abort;
  logic                     in_valid;
  logic                     in_ready;
  logic                     stage_adv;
  logic [ADDR_W-1:0]        bf_mode;
  logic [ADDR_W*ADDR_W-1:0] tw_idx;
  logic                     out_valid;
  logic                     out_last;
  logic                     busy;
  logic                     done;

  modport master (
    output abort, in_valid,
    input  in_ready, stage_adv, bf_mode, tw_idx, out_valid, out_last, busy, done
  );

  modport slave (
    input  abort, in_valid,
    output in_ready, stage_adv, bf_mode, tw_idx, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/sdf_ntt_ctrl.sv
// rtl/sdf_ntt_ctrl.sv - sequencing controller for a radix-2 single-path delay-feedback NTT pipeline
// One global advance counter g drives every stage's window, mode and twiddle decode.
module sdf_ntt_ctrl #(
  parameter int ADDR_W = 6,
  parameter int BF_LAT = 1,
  parameter int CNT_W  = 8
) (
  input logic           clk,
  input logic           rst_n,
  sdf_ntt_ctrl_if.slave ctrl_if
);

  localparam int N     = 1 << ADDR_W;
  localparam int TOTAL = (N - 1) + ADDR_W * BF_LAT;

  localparam logic [CNT_W-1:0] G_FILL_END = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] G_LAST     = CNT_W'(N + TOTAL - 1);
  localparam logic [CNT_W-1:0] G_OUT0     = CNT_W'(TOTAL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  g_q, g_d;
  logic              done_q, done_d;
  logic              in_ready_w;
  logic              stage_adv_w;
  logic [ADDR_W-1:0]        bf_mode_w;
  logic [ADDR_W*ADDR_W-1:0] tw_idx_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      done_q  <= done_d;
    end
  end

  // abort outranks every transition; g only moves on an advance
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    done_d  = 1'b0;
    if (ctrl_if.abort) begin
      state_d = S_IDLE;
      g_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_if.in_valid) begin
            state_d = S_RUN;
            g_d     = CNT_W'(1);
          end
        end
        S_RUN: begin
          if (ctrl_if.in_valid) begin
            g_d = g_q + CNT_W'(1);
            if (g_q == G_FILL_END) begin
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (g_q == G_LAST) begin
            state_d = S_IDLE;
            g_d     = '0;
            done_d  = 1'b1;
          end else begin
            g_d = g_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          g_d     = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready_w  = 1'b0;
    stage_adv_w = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        in_ready_w  = 1'b1;
        stage_adv_w = ctrl_if.in_valid;
      end
      S_DRAIN: stage_adv_w = 1'b1;
      default: ;
    endcase
    if (ctrl_if.abort) begin
      in_ready_w  = 1'b0;
      stage_adv_w = 1'b0;
    end
  end

  // stage s sees the frame delayed by off_s advances; c is its position in that window
  for (genvar s = 0; s < ADDR_W; s++) begin : g_stage
    localparam int OFF = N - (N >> s) + s * BF_LAT;
    logic              active;
    logic [ADDR_W-1:0] c;
    logic [ADDR_W-1:0] k;
    assign active = (g_q >= CNT_W'(OFF)) && (g_q < CNT_W'(OFF + N));
    assign c      = ADDR_W'(g_q - CNT_W'(OFF));
    assign k      = c >> (ADDR_W - s);
    assign bf_mode_w[s] = active & c[ADDR_W-1-s];
    assign tw_idx_w[s*ADDR_W +: ADDR_W] = active ? (ADDR_W'((1 << s) - 1) + k) : '0;
  end

  assign ctrl_if.in_ready  = in_ready_w;
  assign ctrl_if.stage_adv = stage_adv_w;
  assign ctrl_if.bf_mode   = bf_mode_w;
  assign ctrl_if.tw_idx    = tw_idx_w;
  assign ctrl_if.out_valid = stage_adv_w & (g_q >= G_OUT0);
  assign ctrl_if.out_last  = stage_adv_w & (g_q >= G_OUT0) & (g_q == G_LAST);
  assign ctrl_if.busy      = (state_q != S_IDLE);
  assign ctrl_if.done      = done_q;

endmodule

// File: tb/tb_sdf_ntt_ctrl.sv
// tb/tb_sdf_ntt_ctrl.sv - randomized self-checking bench for sdf_ntt_ctrl against a frame-level model
module tb_sdf_ntt_ctrl;

  localparam int ADDR_W = 6;
  localparam int BF_LAT = 1;
  localparam int CNT_W  = 8;
  localparam int N      = 64;
  localparam int TOTAL  = 69;
  localparam int LAST   = 132;
  localparam int VW     = 6 + ADDR_W + ADDR_W * ADDR_W;
  localparam logic [VW-1:0] IDLE_VEC = {1'b1, {(VW-1){1'b0}}};

  logic clk;
  logic rst_n;
  bit   vld;
  bit   abt;

  int vectors;
  int miscompares;

  int mphase;
  int mg;
  bit mdone;

  logic [VW-1:0] exp_v;
  logic [VW-1:0] obs_v;

  sdf_ntt_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  assign bus.in_valid = vld;
  assign bus.abort    = abt;

  sdf_ntt_ctrl #(
    .ADDR_W(ADDR_W),
    .BF_LAT(BF_LAT),
    .CNT_W (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctrl_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] sample();
    return {bus.in_ready, bus.stage_adv, bus.busy, bus.done, bus.out_valid,
            bus.out_last, bus.bf_mode, bus.tw_idx};
  endfunction

  task automatic model_reset();
    mphase = 0;
    mg     = 0;
    mdone  = 1'b0;
  endtask

  task automatic model_commit();
    if (!rst_n || abt) begin
      model_reset();
    end else begin
      case (mphase)
        0: begin
          mdone = 1'b0;
          if (vld) begin mphase = 1; mg = 1; end
        end
        1: begin
          mdone = 1'b0;
          if (vld) begin
            mg++;
            if (mg == N) mphase = 2;
          end
        end
        default: begin
          mdone = 1'b0;
          mg++;
          if (mg == LAST + 1) begin mphase = 0; mg = 0; mdone = 1'b1; end
        end
      endcase
    end
  endtask

  task automatic model_expect(output logic [VW-1:0] e);
    bit rdy, adv, ov, lst;
    logic [ADDR_W-1:0]        bf;
    logic [ADDR_W*ADDR_W-1:0] tw;
    int off, c;
    rdy = (mphase != 2) && !abt;
    adv = abt ? 1'b0 : ((mphase == 2) ? 1'b1 : vld);
    ov  = adv && (mg >= TOTAL);
    lst = ov && (mg == LAST);
    bf  = '0;
    tw  = '0;
    for (int s = 0; s < ADDR_W; s++) begin
      off = N - N / (2 ** s) + s * BF_LAT;
      if (mg >= off && mg < off + N) begin
        c = mg - off;
        bf[s] = 1'((c / (2 ** (ADDR_W - 1 - s))) % 2);
        tw[s*ADDR_W +: ADDR_W] = 6'((2 ** s) - 1 + c / (2 ** (ADDR_W - s)));
      end
    end
    e = {rdy, adv, (mphase != 0), mdone, ov, lst, bf, tw};
  endtask

  task automatic tick(input bit v, input bit a);
    @(posedge clk);
    model_commit();
    #1;
    vld = v;
    abt = a;
    @(negedge clk);
    model_expect(exp_v);
    obs_v = sample();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld = 1'b0;
    abt = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (sample() !== IDLE_VEC) begin
      miscompares++;
      $display("FAIL reset_hold obs=%h exp=%h", sample(), IDLE_VEC);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d obs=%h exp=%h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_continuous();
    int run, max_run, ov_cnt, done_i, last_i;
    run = 0; max_run = 0; ov_cnt = 0; done_i = -1; last_i = -1;
    for (int i = 0; i < 136; i++) begin
      tick(i < 133, 1'b0);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL continuous cyc=%0d g=%0d obs=%h exp=%h", i, mg, obs_v, exp_v);
      end
      run = bus.stage_adv ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (bus.out_valid) ov_cnt++;
      if (bus.out_last) last_i = i;
      if (bus.done) done_i = i;
    end
    vectors++;
    if (max_run !== 133 || ov_cnt !== 64) begin
      miscompares++;
      $display("FAIL continuous_counts adv_run=%0d ov=%0d exp 133/64", max_run, ov_cnt);
    end
    vectors++;
    if (last_i !== 132 || done_i !== 133) begin
      miscompares++;
      $display("FAIL continuous_end last_cyc=%0d done_cyc=%0d exp 132/133", last_i, done_i);
    end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 136; i++) begin
      tick(i < 64, 1'b0);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL decode cyc=%0d g=%0d obs=%h exp=%h", i, mg, obs_v, exp_v);
      end
      if (mg == 31 || mg == 32 || mg == 70 || mg == 130) begin
        vectors++;
        if ((mg == 31 && bus.bf_mode[0] !== 1'b0) ||
            (mg == 32 && (bus.bf_mode[0] !== 1'b1 || bus.tw_idx[5:0] !== 6'd0)) ||
            (mg == 70 && (bus.bf_mode[5] !== 1'b1 || bus.tw_idx[35:30] !== 6'd32)) ||
            (mg == 130 && bus.tw_idx[35:30] !== 6'd62)) begin
          miscompares++;
          $display("FAIL decode_point g=%0d bf=%b tw5=%0d tw0=%0d", mg, bus.bf_mode,
                   bus.tw_idx[35:30], bus.tw_idx[5:0]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int ov_cnt, gap_left;
    bit gap_done, started, finished, v;
    logic [ADDR_W*ADDR_W-1:0] tw_frozen;
    ov_cnt = 0; gap_left = 0; gap_done = 0; started = 0; finished = 0;
    tw_frozen = '0;
    for (int i = 0; i < 400 && !finished; i++) begin
      if (mphase == 1 && mg == 30 && !gap_done) begin
        gap_left = 5; gap_done = 1; tw_frozen = bus.tw_idx;
      end
      if (gap_left > 0) begin
        v = 1'b0; gap_left--;
      end else begin
        v = (!started) || ($urandom_range(0, 3) != 0);
      end
      tick(v, 1'b0);
      started = 1;
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL gaps cyc=%0d g=%0d obs=%h exp=%h", i, mg, obs_v, exp_v);
      end
      if (gap_done && mg == 30 && mphase == 1 && !v) begin
        vectors++;
        if (bus.stage_adv !== 1'b0 || bus.tw_idx !== tw_frozen) begin
          miscompares++;
          $display("FAIL gap_freeze adv=%b tw=%h exp 0/%h", bus.stage_adv, bus.tw_idx, tw_frozen);
        end
      end
      if (bus.out_valid) ov_cnt++;
      if (mdone) finished = 1;
    end
    vectors++;
    if (!finished || ov_cnt !== 64) begin
      miscompares++;
      $display("FAIL gaps_count finished=%0d ov=%0d exp 1/64", finished, ov_cnt);
    end
  endtask

  task automatic test_abort();
    int done_cnt, last_cnt, ab_g;
    bit hit;
    done_cnt = 0; last_cnt = 0;
    // drain-phase abort at g=80, then randomized abort during a gappy RUN
    for (int pass = 0; pass < 2; pass++) begin
      ab_g = (pass == 0) ? 80 : $urandom_range(1, 62);
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
        hit = (mg == ab_g) && (mphase != 0);
        tick(hit ? 1'b0 : ((mphase == 0 && i == 0) || $urandom_range(0, 2) != 0 || pass == 0),
             hit);
        vectors++;
        if (obs_v !== exp_v) begin
          miscompares++;
          $display("FAIL abort_run pass=%0d g=%0d obs=%h exp=%h", pass, mg, obs_v, exp_v);
        end
        if (bus.out_last) last_cnt++;
      end
      for (int i = 0; i < 4; i++) begin
        tick(1'b0, 1'b0);
        vectors++;
        if (obs_v !== exp_v || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_after pass=%0d obs=%h exp=%h", pass, obs_v, exp_v);
        end
      end
    end
    vectors++;
    if (last_cnt !== 0) begin
      miscompares++;
      $display("FAIL abort_no_last last=%0d exp 0", last_cnt);
    end
    last_cnt = 0;
    for (int i = 0; i < 136; i++) begin
      tick(i < 64, 1'b0);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL abort_recover cyc=%0d obs=%h exp=%h", i, obs_v, exp_v);
      end
      if (bus.done) done_cnt++;
      if (bus.out_last) last_cnt++;
    end
    vectors++;
    if (done_cnt !== 1 || last_cnt !== 1) begin
      miscompares++;
      $display("FAIL abort_recover_end done=%0d last=%0d exp 1/1", done_cnt, last_cnt);
    end
  endtask

  task automatic test_async_reset();
    int ov_cnt;
    ov_cnt = 0;
    for (int i = 0; i < 100 && mg != 20; i++) begin
      tick(1'b1, 1'b0);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL areset_pre g=%0d obs=%h exp=%h", mg, obs_v, exp_v);
      end
    end
    @(posedge clk);
    #2;
    vld = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (sample() !== IDLE_VEC) begin
      miscompares++;
      $display("FAIL areset_now obs=%h exp=%h", sample(), IDLE_VEC);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 136; i++) begin
      tick(i < 64, 1'b0);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL areset_frame cyc=%0d obs=%h exp=%h", i, obs_v, exp_v);
      end
      if (bus.out_valid) ov_cnt++;
    end
    vectors++;
    if (ov_cnt !== 64) begin
      miscompares++;
      $display("FAIL areset_count ov=%0d exp 64", ov_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int ov_cnt;
    ov_cnt = 0;
    for (int i = 0; i < 270; i++) begin
      tick((i < 64) || (i >= 133 && i < 197) || ($urandom_range(0, 1) == 1 && i < 133), 1'b0);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d g=%0d obs=%h exp=%h", i, mg, obs_v, exp_v);
      end
      if (i == 133) begin
        vectors++;
        if (bus.done !== 1'b1 || bus.stage_adv !== 1'b1 || bus.in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_accept done=%b adv=%b rdy=%b exp 1/1/1", bus.done, bus.stage_adv,
                   bus.in_ready);
        end
      end
      if (bus.out_valid) ov_cnt++;
    end
    vectors++;
    if (ov_cnt !== 128) begin
      miscompares++;
      $display("FAIL b2b_count ov=%0d exp 128", ov_cnt);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    vld = 1'b0;
    abt = 1'b0;
    model_reset();
    test_reset();
    test_continuous();
    test_decode();
    test_gaps();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
